output_config_bank: RTL and testbench

//  Memory-mapped configuration bank for N LED output channels, driven by the SPI write bus.

---
 rtl/output_config_bank.sv | 255 +++++++++++++++++++++++++
 tb/tb_output_config_bank.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_config_bank.sv
// Shadow/active configuration bank for the LED output channels with a frame-synchronous commit.
// Optional registered readback port is built when CFG_READBACK_EN is defined.
module output_config_bank #(
    parameter int unsigned ADDRESS_BUS_WIDTH = 16,
    parameter int unsigned DATA_BUS_WIDTH    = 16,
    parameter int unsigned OUTPUT_COUNT      = 10,
    parameter int unsigned CFG_BASE          = 32'h8000,
    parameter int unsigned TIMEOUT_CYCLES    = 65535
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [ADDRESS_BUS_WIDTH-1:0]                wr_address,
    input  logic [DATA_BUS_WIDTH-1:0]                   wr_data,
    input  logic                                        wr_strobe,
    input  logic [OUTPUT_COUNT-1:0]                     channel_busy,
    output logic [OUTPUT_COUNT*ADDRESS_BUS_WIDTH-1:0]   word_counts,
    output logic [OUTPUT_COUNT*ADDRESS_BUS_WIDTH-1:0]   start_addresses,
    output logic [OUTPUT_COUNT-1:0]                     channel_resets,
    output logic                                        commit_busy,
    output logic                                        commit_done,
    output logic                                        timeout_flag,
    input  logic [ADDRESS_BUS_WIDTH-1:0]                rd_address,
    output logic [DATA_BUS_WIDTH-1:0]                   rd_data
);

    localparam int unsigned AW = ADDRESS_BUS_WIDTH;
    localparam int unsigned DW = DATA_BUS_WIDTH;
    localparam int unsigned N  = OUTPUT_COUNT;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW-1:0] BASE         = AW'(CFG_BASE);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_MAX  = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StQuiesce, StLoad, StRelease} state_e;

    state_e state_q, state_d;

    logic [N-1:0][AW-1:0] wc_shadow_q, wc_shadow_d;
    logic [N-1:0][AW-1:0] sa_shadow_q, sa_shadow_d;
    logic [N-1:0]         en_shadow_q, en_shadow_d;
    logic [N-1:0][AW-1:0] wc_active_q, wc_active_d;
    logic [N-1:0][AW-1:0] sa_active_q, sa_active_d;
    logic [N-1:0]         en_active_q, en_active_d;
    logic [N-1:0]         channel_resets_q, channel_resets_d;
    logic                 pending_q, pending_d;
    logic                 timeout_flag_q, timeout_flag_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    // Write decode
    logic [AW-1:0] wr_offset;
    logic [AW-1:0] wr_word;
    logic          wr_in_window;
    logic [1:0]    wr_group;
    logic [3:0]    wr_index;
    logic          wr_index_ok;
    logic          wc_wr, sa_wr, en_wr, ctrl_wr;
    logic          commit_req, abort_req, clear_req;

    assign wr_offset    = wr_address - BASE;
    assign wr_word      = AW'(wr_data);
    assign wr_in_window = wr_strobe && (wr_offset < AW'(64));
    assign wr_group     = wr_offset[5:4];
    assign wr_index     = wr_offset[3:0];
    assign wr_index_ok  = (32'(wr_index) < N);

    assign wc_wr   = wr_in_window && (wr_group == 2'd0) && wr_index_ok;
    assign sa_wr   = wr_in_window && (wr_group == 2'd1) && wr_index_ok;
    assign en_wr   = wr_in_window && (wr_group == 2'd2) && wr_index_ok;
    assign ctrl_wr = wr_in_window && (wr_offset[5:0] == 6'h30);

    assign commit_req = ctrl_wr && wr_data[0];
    assign abort_req  = ctrl_wr && wr_data[1];
    assign clear_req  = ctrl_wr && wr_data[2];

    // Sequencer status
    logic busy_state;
    logic quiet;
    logic timed_out;
    logic set_pending;
    logic force_load;

    assign busy_state  = (state_q != StIdle);
    assign quiet       = ((channel_busy & en_active_q) == '0);
    assign timed_out   = (cnt_q == TIMEOUT_LAST);
    // A busy-time commit that arrives together with abort is dropped: abort wins.
    assign set_pending = commit_req && !abort_req && busy_state;
    assign force_load  = (state_q == StQuiesce) && !abort_req && !quiet && timed_out;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (commit_req) state_d = StQuiesce;
            end
            StQuiesce: begin
                if (abort_req) begin
                    state_d = StIdle;
                end else if (quiet || timed_out) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StRelease;
            end
            StRelease: begin
                state_d = (pending_q || set_pending) ? StQuiesce : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        commit_busy = busy_state;
        commit_done = (state_q == StRelease);
    end

    // Datapath next state
    always_comb begin
        wc_shadow_d      = wc_shadow_q;
        sa_shadow_d      = sa_shadow_q;
        en_shadow_d      = en_shadow_q;
        wc_active_d      = wc_active_q;
        sa_active_d      = sa_active_q;
        en_active_d      = en_active_q;
        channel_resets_d = channel_resets_q;
        pending_d        = pending_q;
        timeout_flag_d   = timeout_flag_q;
        cnt_d            = cnt_q;

        for (int i = 0; i < int'(N); i++) begin
            if (wr_index == 4'(i)) begin
                if (wc_wr) wc_shadow_d[i] = wr_word;
                if (sa_wr) sa_shadow_d[i] = wr_word;
                if (en_wr) en_shadow_d[i] = wr_data[0];
            end
        end

        // Active copy samples the pre-write shadow, so a LOAD-cycle write waits for the next commit.
        if (state_q == StLoad) begin
            wc_active_d = wc_shadow_q;
            sa_active_d = sa_shadow_q;
            en_active_d = en_shadow_q;
        end

        if (state_d == StLoad) begin
            channel_resets_d = '1;
        end else if (state_q == StLoad) begin
            channel_resets_d = ~en_shadow_q;
        end

        if ((state_q == StQuiesce) && abort_req) begin
            pending_d = 1'b0;
        end else if (state_q == StRelease) begin
            pending_d = 1'b0;
        end else if (set_pending) begin
            pending_d = 1'b1;
        end

        if ((state_d == StQuiesce) && (state_q != StQuiesce)) begin
            cnt_d = '0;
        end else if ((state_q == StQuiesce) && (cnt_q != TIMEOUT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (clear_req) timeout_flag_d = 1'b0;
        if (force_load) timeout_flag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wc_shadow_q      <= '0;
            sa_shadow_q      <= '0;
            en_shadow_q      <= '0;
            wc_active_q      <= '0;
            sa_active_q      <= '0;
            en_active_q      <= '0;
            channel_resets_q <= '1;
            pending_q        <= 1'b0;
            timeout_flag_q   <= 1'b0;
            cnt_q            <= '0;
        end else begin
            wc_shadow_q      <= wc_shadow_d;
            sa_shadow_q      <= sa_shadow_d;
            en_shadow_q      <= en_shadow_d;
            wc_active_q      <= wc_active_d;
            sa_active_q      <= sa_active_d;
            en_active_q      <= en_active_d;
            channel_resets_q <= channel_resets_d;
            pending_q        <= pending_d;
            timeout_flag_q   <= timeout_flag_d;
            cnt_q            <= cnt_d;
        end
    end

    assign word_counts     = wc_active_q;
    assign start_addresses = sa_active_q;
    assign channel_resets  = channel_resets_q;
    assign timeout_flag    = timeout_flag_q;

`ifdef CFG_READBACK_EN
    logic [AW-1:0] rd_offset;
    logic [DW-1:0] rd_data_d, rd_data_q;

    assign rd_offset = rd_address - BASE;

    always_comb begin
        rd_data_d = '0;
        if (rd_offset < AW'(64)) begin
            if (rd_offset[5:0] == 6'h31) begin
                rd_data_d = DW'({pending_q, timeout_flag_q, busy_state});
            end else begin
                for (int i = 0; i < int'(N); i++) begin
                    if (rd_offset[3:0] == 4'(i)) begin
                        case (rd_offset[5:4])
                            2'd0:    rd_data_d = DW'(wc_shadow_q[i]);
                            2'd1:    rd_data_d = DW'(sa_shadow_q[i]);
                            2'd2:    rd_data_d = DW'(en_shadow_q[i]);
                            default: rd_data_d = '0;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`else
    logic unused_rd_address;
    assign unused_rd_address = ^rd_address;
    assign rd_data = '0;
`endif

endmodule

// File: tb/tb_output_config_bank.sv
// Scoreboard bench for output_config_bank: expected active configs are queued at each commit
// and compared by a monitor whenever commit_done pulses.
module tb_output_config_bank;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int TO = 64;
    localparam logic [15:0] BASE = 16'h8000;

    logic             clk;
    logic             rst;
    logic [W-1:0]     wr_address;
    logic [W-1:0]     wr_data;
    logic             wr_strobe;
    logic [N-1:0]     channel_busy;
    logic [N*W-1:0]   word_counts;
    logic [N*W-1:0]   start_addresses;
    logic [N-1:0]     channel_resets;
    logic             commit_busy;
    logic             commit_done;
    logic             timeout_flag;
    logic [W-1:0]     rd_address;
    logic [W-1:0]     rd_data;

    output_config_bank #(
        .ADDRESS_BUS_WIDTH(W),
        .DATA_BUS_WIDTH   (W),
        .OUTPUT_COUNT     (N),
        .CFG_BASE         (32'h8000),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_address     (wr_address),
        .wr_data        (wr_data),
        .wr_strobe      (wr_strobe),
        .channel_busy   (channel_busy),
        .word_counts    (word_counts),
        .start_addresses(start_addresses),
        .channel_resets (channel_resets),
        .commit_busy    (commit_busy),
        .commit_done    (commit_done),
        .timeout_flag   (timeout_flag),
        .rd_address     (rd_address),
        .rd_data        (rd_data)
    );

    typedef struct packed {
        logic [N*W-1:0] wc;
        logic [N*W-1:0] sa;
        logic [N-1:0]   rs;
    } snap_t;

    snap_t exp_q[$];
    snap_t mon_e;

    logic [W-1:0] m_wc[N];
    logic [W-1:0] m_sa[N];
    logic [N-1:0] m_en;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic snap_t model_snap();
        snap_t s;
        for (int i = 0; i < N; i++) begin
            s.wc[i*W +: W] = m_wc[i];
            s.sa[i*W +: W] = m_sa[i];
            s.rs[i]        = ~m_en[i];
        end
        return s;
    endfunction

    // Scoreboard monitor: every commit_done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && commit_done === 1'b1) begin
            done_seen++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL done_unexpected: got commit_done=1, required no pulse");
            end else begin
                mon_e = exp_q.pop_front();
                if (word_counts !== mon_e.wc || start_addresses !== mon_e.sa ||
                    channel_resets !== mon_e.rs) begin
                    fails++;
                    $display("FAIL done_config: got wc=%h sa=%h rs=%h, required wc=%h sa=%h rs=%h",
                             word_counts, start_addresses, channel_resets,
                             mon_e.wc, mon_e.sa, mon_e.rs);
                end
            end
        end
    end

    // Independent address-map model updated as writes are issued.
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        int off;
        int idx;
        off = int'(a) - int'(BASE);
        if (off >= 0 && off < 64) begin
            idx = off % 16;
            if (idx < N) begin
                case (off / 16)
                    0: m_wc[idx] = d;
                    1: m_sa[idx] = d;
                    2: m_en[idx] = d[0];
                    default: ;
                endcase
            end
        end
        wr_address = a;
        wr_data    = d;
        wr_strobe  = 1'b1;
        @(posedge clk);
        #1;
        wr_strobe  = 1'b0;
    endtask

    task automatic commit(input bit exp_done);
        if (exp_done) exp_q.push_back(model_snap());
        wr(BASE + 16'h30, 16'h0001);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (commit_done === 1'b1) begin
                n = i;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wr_address = '0;
        wr_data = '0;
        wr_strobe = 1'b0;
        channel_busy = '0;
        rd_address = BASE + 16'h31;
        for (int i = 0; i < N; i++) begin
            m_wc[i] = '0;
            m_sa[i] = '0;
        end
        m_en = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (channel_resets !== 10'h3FF) begin
            fails++;
            $display("FAIL reset_resets: got %h, required 3ff", channel_resets);
        end
        tests++;
        if (word_counts !== '0 || start_addresses !== '0) begin
            fails++;
            $display("FAIL reset_regs: got wc=%h sa=%h, required 0", word_counts, start_addresses);
        end
        tests++;
        if (commit_busy !== 1'b0 || commit_done !== 1'b0 || timeout_flag !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: got busy=%b done=%b to=%b, required 0 0 0",
                     commit_busy, commit_done, timeout_flag);
        end
        tests++;
        if (rd_data !== '0) begin
            fails++;
            $display("FAIL reset_rd_data: got %h, required 0", rd_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (channel_resets !== 10'h3FF || commit_busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: got rs=%h busy=%b, required 3ff 0", channel_resets, commit_busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_commit_basic();
        wr(BASE + 16'h02, 16'h0120);
        wr(BASE + 16'h12, 16'h0400);
        wr(BASE + 16'h22, 16'h0001);
        commit(1);
        @(negedge clk);  // T+1
        tests++;
        if (commit_busy !== 1'b1 || commit_done !== 1'b0 || word_counts !== '0) begin
            fails++;
            $display("FAIL basic_t1: got busy=%b done=%b wc=%h, required 1 0 0",
                     commit_busy, commit_done, word_counts);
        end
        @(negedge clk);  // T+2
        tests++;
        if (commit_done !== 1'b0 || word_counts !== '0 || channel_resets !== 10'h3FF) begin
            fails++;
            $display("FAIL basic_t2: got done=%b wc=%h rs=%h, required 0 0 3ff",
                     commit_done, word_counts, channel_resets);
        end
        @(negedge clk);  // T+3
        tests++;
        if (commit_done !== 1'b1 || word_counts[2*W +: W] !== 16'h0120 ||
            start_addresses[2*W +: W] !== 16'h0400 || channel_resets !== 10'h3FB) begin
            fails++;
            $display("FAIL basic_t3: got done=%b wc2=%h sa2=%h rs=%h, required 1 0120 0400 3fb",
                     commit_done, word_counts[2*W +: W], start_addresses[2*W +: W], channel_resets);
        end
        @(negedge clk);  // T+4
        tests++;
        if (commit_done !== 1'b0 || commit_busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_t4: got done=%b busy=%b, required 0 0", commit_done, commit_busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_wait();
        int n;
        bit bad;
        bad = 1'b0;
        channel_busy = 10'b00_0000_0100;
        wr(BASE + 16'h02, 16'h0130);
        commit(1);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (commit_busy !== 1'b1 || commit_done !== 1'b0 || word_counts[2*W +: W] !== 16'h0120)
                bad = 1'b1;
            @(posedge clk);
            #1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL busy_hold: got early load or idle, required QUIESCE held");
        end
        channel_busy = '0;
        wait_done(n);
        tests++;
        if (n !== 3) begin
            fails++;
            $display("FAIL busy_release_latency: got %0d, required 3", n);
        end
        tests++;
        if (timeout_flag !== 1'b0 || word_counts[2*W +: W] !== 16'h0130) begin
            fails++;
            $display("FAIL busy_result: got to=%b wc2=%h, required 0 0130",
                     timeout_flag, word_counts[2*W +: W]);
        end
    endtask

    task automatic test_timeout();
        int n;
        channel_busy = 10'b00_0000_0100;
        wr(BASE + 16'h12, 16'h0500);
        commit(1);
        wait_done(n);
        tests++;
        if (n !== TO + 2) begin
            fails++;
            $display("FAIL timeout_latency: got %0d, required %0d", n, TO + 2);
        end
        tests++;
        if (timeout_flag !== 1'b1) begin
            fails++;
            $display("FAIL timeout_flag_set: got %b, required 1", timeout_flag);
        end
        wr(BASE + 16'h30, 16'h0004);
        @(negedge clk);
        tests++;
        if (timeout_flag !== 1'b0 || commit_busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear: got to=%b busy=%b, required 0 0", timeout_flag, commit_busy);
        end
        @(posedge clk);
        #1;
        channel_busy = '0;
    endtask

    task automatic test_pending_abort();
        int n;
        int start;
        start = done_seen;
        channel_busy = 10'b00_0000_0100;
        commit(1);
        commit(0);
        channel_busy = '0;
        wait_done(n);
        tests++;
        if (n !== 3) begin
            fails++;
            $display("FAIL pending_first_latency: got %0d, required 3", n);
        end
        channel_busy = 10'b00_0000_0100;
        @(negedge clk);
        tests++;
        if (commit_busy !== 1'b1) begin
            fails++;
            $display("FAIL pending_requiesce: got busy=%b, required 1", commit_busy);
        end
        @(posedge clk);
        #1;
        wr(BASE + 16'h30, 16'h0002);
        @(negedge clk);
        tests++;
        if (commit_busy !== 1'b0 || channel_resets !== 10'h3FB) begin
            fails++;
            $display("FAIL abort_idle: got busy=%b rs=%h, required 0 3fb", commit_busy, channel_resets);
        end
        repeat (TO + 10) @(posedge clk);
        #1;
        tests++;
        if (done_seen - start !== 1 || commit_busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_single_done: got dones=%0d busy=%b, required 1 0",
                     done_seen - start, commit_busy);
        end
        channel_busy = '0;
        commit(1);
        wait_done(n);
        @(negedge clk);
        tests++;
        if (n !== 3 || commit_busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_pending_cleared: got n=%0d busy=%b, required 3 0", n, commit_busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignored_writes();
        int n;
        wr(BASE + 16'h0A, 16'hBEEF);
        wr(BASE + 16'h2A, 16'h0001);
        wr(BASE + 16'h3F, 16'hFFFF);
        wr(BASE + 16'h40, 16'h5555);
        wr(BASE - 16'h01, 16'h0001);
        wr(BASE + 16'h09, 16'h0999);
        wr(BASE + 16'h20, 16'h0001);
        commit(1);
        wait_done(n);
        tests++;
        if (n !== 3) begin
            fails++;
            $display("FAIL ignored_latency: got %0d, required 3", n);
        end
        tests++;
        if (word_counts[9*W +: W] !== 16'h0999 || word_counts[0 +: W] !== 16'h0000 ||
            channel_resets !== 10'h3FA) begin
            fails++;
            $display("FAIL ignored_regs: got wc9=%h wc0=%h rs=%h, required 0999 0000 3fa",
                     word_counts[9*W +: W], word_counts[0 +: W], channel_resets);
        end
    endtask

    task automatic test_load_collision();
        int n;
        commit(1);
        @(posedge clk);
        #1;
        wr(BASE + 16'h03, 16'h0333);  // lands in the LOAD cycle
        @(negedge clk);
        tests++;
        if (commit_done !== 1'b1 || word_counts[3*W +: W] !== 16'h0000) begin
            fails++;
            $display("FAIL load_collision_old: got done=%b wc3=%h, required 1 0000",
                     commit_done, word_counts[3*W +: W]);
        end
        @(posedge clk);
        #1;
        commit(1);
        wait_done(n);
        tests++;
        if (n !== 3 || word_counts[3*W +: W] !== 16'h0333) begin
            fails++;
            $display("FAIL load_collision_next: got n=%0d wc3=%h, required 3 0333",
                     n, word_counts[3*W +: W]);
        end
    endtask

    task automatic test_reset_mid_commit();
        channel_busy = 10'b00_0000_0100;
        commit(0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #2;
        tests++;
        if (channel_resets !== 10'h3FF || word_counts !== '0 || start_addresses !== '0 ||
            commit_busy !== 1'b0 || timeout_flag !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_commit: got rs=%h wc=%h sa=%h busy=%b to=%b, required reset values",
                     channel_resets, word_counts, start_addresses, commit_busy, timeout_flag);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        channel_busy = '0;
        for (int i = 0; i < N; i++) begin
            m_wc[i] = '0;
            m_sa[i] = '0;
        end
        m_en = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (commit_busy !== 1'b0 || channel_resets !== 10'h3FF) begin
            fails++;
            $display("FAIL reset_fsm_idle: got busy=%b rs=%h, required 0 3ff", commit_busy, channel_resets);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_commit_basic();
        test_busy_wait();
        test_timeout();
        test_pending_abort();
        test_ignored_writes();
        test_load_collision();
        test_reset_mid_commit();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
